// File: rtl/fetch_pc_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_pc_ctrl
//
// Fetch-stage program-counter controller placed in front of the branch target
// buffer. It drives the BTB lookup address, uses the BTB hit and target to pick
// the next fetch PC, and keeps a small FIFO of taken predictions that are still
// in flight. When a branch resolves in EX, the FIFO head is compared with the
// real outcome. On a mispredict the controller flushes, redirects the PC, and
// schedules a BTB update write.
//
// Parameters
//   RESET_PC        fetch address loaded by reset
//   QDEPTH          prediction-queue entries (power of two, >= 2)
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   stall           IF/ID hold request from hazard logic
//   pc_if           current fetch PC (BTB pc_in and I-memory address)
//   bp_hit          BTB hit for pc_if
//   bp_target       BTB predicted target for pc_if
//   fetch_valid     IF/ID may capture the instruction at pc_if this cycle
//   pred_taken_if   captured instruction was predicted taken
//   ex_valid        a valid instruction occupies EX
//   ex_is_br        EX instruction is a branch or jump
//   ex_pc           PC of the EX instruction
//   ex_taken        resolved branch direction
//   ex_target       resolved branch target
//   flush           kills IF/ID and ID/EX contents (combinational)
//   br_update       BTB write strobe (registered, one cycle)
//   target_pc       BTB write target (registered)
//   pc_ex           BTB write index/tag PC (registered)
//   mispredict_cnt  saturating count of mispredict cycles
// -----------------------------------------------------------------------------
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  output logic [31:0] pc_if,
  input  logic        bp_hit,
  input  logic [31:0] bp_target,
  output logic        fetch_valid,
  output logic        pred_taken_if,
  input  logic        ex_valid,
  input  logic        ex_is_br,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic        flush,
  output logic        br_update,
  output logic [31:0] target_pc,
  output logic [31:0] pc_ex,
  output logic [15:0] mispredict_cnt
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = AW + 1;   // count must be able to hold QDEPTH itself

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]   pc_reg, pc_next;
  logic [AW-1:0] head_reg, head_next;
  logic [AW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;
  logic          br_update_reg, br_update_next;
  logic [31:0]   target_pc_reg, target_pc_next;
  logic [31:0]   pc_ex_reg, pc_ex_next;
  logic [15:0]   mp_cnt_reg, mp_cnt_next;

  // Prediction-queue storage, one slot per generate instance
  logic [31:0]   slot_pc  [QDEPTH];
  logic [31:0]   slot_tgt [QDEPTH];

  // ---------------------------------------------------------------------------
  // Resolution logic
  // ---------------------------------------------------------------------------
  logic        q_empty;
  logic        q_full;
  logic [31:0] head_pc;
  logic [31:0] head_tgt;
  logic        head_match;
  logic        pop_ok;
  logic        mp_seq;       // predicted taken but falls through
  logic        mp_tgt;       // actually taken but not predicted this way
  logic        mp;
  logic [31:0] correct_pc;
  logic        push;

  assign q_empty  = (count_reg == '0);
  assign q_full   = (count_reg == CW'(QDEPTH));
  assign head_pc  = slot_pc[head_reg];
  assign head_tgt = slot_tgt[head_reg];

  assign head_match = ex_valid && !q_empty && (head_pc == ex_pc);
  assign pop_ok     = head_match && ex_is_br && ex_taken && (head_tgt == ex_target);

  // A head match on a non-branch (false BTB hit) or a not-taken branch means
  // fetch went to the wrong target; the correct path is the fall-through.
  assign mp_seq = head_match && (!ex_is_br || !ex_taken);

  // Any taken branch that did not pop a matching prediction was fetched down
  // the wrong path: either no prediction at all, or the predicted target
  // differs. Both cases redirect to ex_target. This is also the exact
  // condition for a BTB update.
  assign mp_tgt = ex_valid && ex_is_br && ex_taken && !pop_ok;

  assign mp         = mp_seq || mp_tgt;
  assign correct_pc = mp_seq ? (ex_pc + 32'd4) : ex_target;

  // A hit while the queue is full can only be accepted if a pop frees a slot
  // in the same cycle.
  assign fetch_valid   = !rst && !mp && !stall && !(bp_hit && q_full && !pop_ok);
  assign pred_taken_if = fetch_valid && bp_hit;
  assign push          = fetch_valid && bp_hit;
  assign flush         = mp;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_next = pc_reg + 32'd4;
    if (mp) begin
      pc_next = correct_pc;
    end else if (!fetch_valid) begin
      pc_next = pc_reg;
    end else if (bp_hit) begin
      pc_next = bp_target;
    end
  end

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (mp) begin
      // Everything still queued was fetched down the wrong path.
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (push) begin
        tail_next = tail_reg + AW'(1);
      end
      if (pop_ok) begin
        head_next = head_reg + AW'(1);
      end
      case ({push, pop_ok})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_comb begin
    br_update_next = mp_tgt;
    target_pc_next = target_pc_reg;
    pc_ex_next     = pc_ex_reg;
    if (mp_tgt) begin
      target_pc_next = ex_target;
      pc_ex_next     = ex_pc;
    end
  end

  always_comb begin
    mp_cnt_next = mp_cnt_reg;
    if (mp && (mp_cnt_reg != 16'hFFFF)) begin
      mp_cnt_next = mp_cnt_reg + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg        <= RESET_PC;
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      br_update_reg <= 1'b0;
      target_pc_reg <= '0;
      pc_ex_reg     <= '0;
      mp_cnt_reg    <= '0;
    end else begin
      pc_reg        <= pc_next;
      head_reg      <= head_next;
      tail_reg      <= tail_next;
      count_reg     <= count_next;
      br_update_reg <= br_update_next;
      target_pc_reg <= target_pc_next;
      pc_ex_reg     <= pc_ex_next;
      mp_cnt_reg    <= mp_cnt_next;
    end
  end

  // Queue slots carry no reset: count/head/tail define which are meaningful.
  // push is already low during reset and mispredict via fetch_valid.
  genvar gi;
  generate
    for (gi = 0; gi < QDEPTH; gi++) begin : g_slot
      logic [31:0] pc_slot_reg;
      logic [31:0] tgt_slot_reg;

      always_ff @(posedge clk) begin
        if (push && (tail_reg == AW'(gi))) begin
          pc_slot_reg  <= pc_reg;
          tgt_slot_reg <= bp_target;
        end
      end

      assign slot_pc[gi]  = pc_slot_reg;
      assign slot_tgt[gi] = tgt_slot_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pc_if          = pc_reg;
  assign br_update      = br_update_reg;
  assign target_pc      = target_pc_reg;
  assign pc_ex          = pc_ex_reg;
  assign mispredict_cnt = mp_cnt_reg;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_ctrl
//
// Self-checking bench for fetch_pc_ctrl (RESET_PC = 0x100, QDEPTH = 4).
// First a directed vector table walks through the main scenarios and corner
// cases. Then randomized cycles are compared against a queue-based reference
// model.
// -----------------------------------------------------------------------------
module tb_fetch_pc_ctrl;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int          QD  = 4;

  logic        clk = 1'b0;
  logic        rst, stall, bp_hit, ex_valid, ex_is_br, ex_taken;
  logic [31:0] bp_target, ex_pc, ex_target;
  logic [31:0] pc_if, target_pc, pc_ex;
  logic        fetch_valid, pred_taken_if, flush, br_update;
  logic [15:0] mispredict_cnt;

  always #5 clk = ~clk;

  fetch_pc_ctrl #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_if(pc_if),
    .bp_hit(bp_hit), .bp_target(bp_target),
    .fetch_valid(fetch_valid), .pred_taken_if(pred_taken_if),
    .ex_valid(ex_valid), .ex_is_br(ex_is_br), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .flush(flush), .br_update(br_update), .target_pc(target_pc),
    .pc_ex(pc_ex), .mispredict_cnt(mispredict_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        rst, stall, hit;
    logic [31:0] bpt;
    logic        exv, exbr;
    logic [31:0] expc;
    logic        ext;
    logic [31:0] extg;
    logic [31:0] e_pc;
    logic        e_fv, e_pt, e_fl, e_bu;
    logic [31:0] e_pe, e_tg;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(
    input logic r, input logic s, input logic h, input logic [31:0] bt,
    input logic ev, input logic eb, input logic [31:0] ep, input logic et,
    input logic [31:0] eg,
    input logic [31:0] xpc, input logic xfv, input logic xpt, input logic xfl,
    input logic xbu, input logic [31:0] xpe, input logic [31:0] xtg,
    input logic [15:0] xcnt);
    vec_t v;
    v.rst = r; v.stall = s; v.hit = h; v.bpt = bt;
    v.exv = ev; v.exbr = eb; v.expc = ep; v.ext = et; v.extg = eg;
    v.e_pc = xpc; v.e_fv = xfv; v.e_pt = xpt; v.e_fl = xfl; v.e_bu = xbu;
    v.e_pe = xpe; v.e_tg = xtg; v.e_cnt = xcnt;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic r, input logic s, input logic h, input logic [31:0] bt,
                       input logic ev, input logic eb, input logic [31:0] ep,
                       input logic et, input logic [31:0] eg);
    rst = r; stall = s; bp_hit = h; bp_target = bt;
    ex_valid = ev; ex_is_br = eb; ex_pc = ep; ex_taken = et; ex_target = eg;
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] xpc, input logic xfv,
                               input logic xpt, input logic xfl, input logic xbu,
                               input logic [31:0] xpe, input logic [31:0] xtg,
                               input logic [15:0] xcnt);
    chk({tag, " pc_if"},          pc_if,                  xpc);
    chk({tag, " fetch_valid"},    32'(fetch_valid),       32'(xfv));
    chk({tag, " pred_taken_if"},  32'(pred_taken_if),     32'(xpt));
    chk({tag, " flush"},          32'(flush),             32'(xfl));
    chk({tag, " br_update"},      32'(br_update),         32'(xbu));
    chk({tag, " pc_ex"},          pc_ex,                  xpe);
    chk({tag, " target_pc"},      target_pc,              xtg);
    chk({tag, " mispredict_cnt"}, 32'(mispredict_cnt),    32'(xcnt));
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: plain queue of outstanding predictions
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc, m_tpc, m_pex;
  logic        m_bu;
  logic [15:0] m_cnt;

  task automatic model_reset();
    m_pc = RPC; mq.delete(); m_bu = 1'b0; m_tpc = '0; m_pex = '0; m_cnt = '0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 255)) << 2;
    if ($urandom_range(0, 15) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    //   rst stl hit bpt     exv br expc     tk extg      pc      fv pt fl bu pe      tg      cnt
    add(1, 0, 0, 0,        0, 0, 0,       0, 0,        'h100,  0, 0, 0, 0, 0,      0,      0);
    add(0, 0, 0, 0,        0, 0, 0,       0, 0,        'h100,  1, 0, 0, 0, 0,      0,      0);
    add(0, 0, 0, 0,        0, 0, 0,       0, 0,        'h104,  1, 0, 0, 0, 0,      0,      0);
    add(0, 0, 1, 'h200,    0, 0, 0,       0, 0,        'h108,  1, 1, 0, 0, 0,      0,      0);
    add(0, 0, 0, 0,        0, 0, 0,       0, 0,        'h200,  1, 0, 0, 0, 0,      0,      0);
    add(0, 0, 0, 0,        1, 1, 'h108,   1, 'h200,    'h204,  1, 0, 0, 0, 0,      0,      0);
    add(1, 0, 0, 0,        0, 0, 0,       0, 0,        'h208,  0, 0, 0, 0, 0,      0,      0);
    add(0, 0, 0, 0,        0, 0, 0,       0, 0,        'h100,  1, 0, 0, 0, 0,      0,      0);
    add(0, 0, 0, 0,        0, 0, 0,       0, 0,        'h104,  1, 0, 0, 0, 0,      0,      0);
    add(0, 0, 1, 'h200,    0, 0, 0,       0, 0,        'h108,  1, 1, 0, 0, 0,      0,      0);
    add(0, 0, 0, 0,        0, 0, 0,       0, 0,        'h200,  1, 0, 0, 0, 0,      0,      0);
    add(0, 0, 0, 0,        1, 1, 'h108,   0, 'h200,    'h204,  0, 0, 1, 0, 0,      0,      0);
    add(0, 0, 0, 0,        0, 0, 0,       0, 0,        'h10C,  1, 0, 0, 0, 0,      0,      1);
    add(0, 0, 0, 0,        1, 1, 'h40,    1, 'h80,     'h110,  0, 0, 1, 0, 0,      0,      1);
    add(0, 0, 0, 0,        0, 0, 0,       0, 0,        'h80,   1, 0, 0, 1, 'h40,   'h80,   2);
    add(0, 0, 1, 'h300,    0, 0, 0,       0, 0,        'h84,   1, 1, 0, 0, 'h40,   'h80,   2);
    add(0, 0, 1, 'h400,    0, 0, 0,       0, 0,        'h300,  1, 1, 0, 0, 'h40,   'h80,   2);
    add(0, 0, 1, 'h500,    0, 0, 0,       0, 0,        'h400,  1, 1, 0, 0, 'h40,   'h80,   2);
    add(0, 0, 1, 'h600,    0, 0, 0,       0, 0,        'h500,  1, 1, 0, 0, 'h40,   'h80,   2);
    add(0, 0, 1, 'h700,    0, 0, 0,       0, 0,        'h600,  0, 0, 0, 0, 'h40,   'h80,   2);
    add(0, 0, 1, 'h700,    1, 1, 'h84,    1, 'h300,    'h600,  1, 1, 0, 0, 'h40,   'h80,   2);
    add(0, 0, 1, 'h800,    0, 0, 0,       0, 0,        'h700,  0, 0, 0, 0, 'h40,   'h80,   2);
    add(0, 1, 0, 0,        1, 1, 'h300,   0, 'h400,    'h700,  0, 0, 1, 0, 'h40,   'h80,   2);
    add(0, 0, 0, 0,        1, 1, 'h50,    1, 'h90,     'h304,  0, 0, 1, 0, 'h40,   'h80,   3);
    add(0, 0, 0, 0,        1, 1, 'h60,    1, 'hA0,     'h90,   0, 0, 1, 1, 'h50,   'h90,   4);
    add(1, 0, 0, 0,        1, 1, 'h70,    1, 'hB0,     'hA0,   0, 0, 1, 1, 'h60,   'hA0,   5);
    add(0, 0, 0, 0,        0, 0, 0,       0, 0,        'h100,  1, 0, 0, 0, 0,      0,      0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].hit, vecs[i].bpt, vecs[i].exv,
            vecs[i].exbr, vecs[i].expc, vecs[i].ext, vecs[i].extg);
      #2;
      check_outputs($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_fv, vecs[i].e_pt,
                    vecs[i].e_fl, vecs[i].e_bu, vecs[i].e_pe, vecs[i].e_tg, vecs[i].e_cnt);
      @(posedge clk);
      #1;
    end

    // -------------------------------------------------------------------------
    // Randomized phase against the reference model
    // -------------------------------------------------------------------------
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    model_reset();

    for (int c = 0; c < 3000; c++) begin
      logic        hm, good, m_mp, m_fv, upd;
      logic [31:0] corr;
      ent_t        e;

      rst       = ($urandom_range(0, 99) == 0);
      stall     = ($urandom_range(0, 5) == 0);
      bp_hit    = ($urandom_range(0, 1) == 0);
      bp_target = rand_addr();
      ex_valid  = ($urandom_range(0, 2) == 0);
      if (mq.size() != 0 && $urandom_range(0, 3) != 0) begin
        ex_pc = mq[0].pc;
        if ($urandom_range(0, 4) != 0) begin
          ex_is_br = 1'b1; ex_taken = 1'b1; ex_target = mq[0].tgt;
        end else begin
          ex_is_br  = ($urandom_range(0, 3) != 0);
          ex_taken  = 1'($urandom_range(0, 1));
          ex_target = ($urandom_range(0, 1) == 0) ? mq[0].tgt : rand_addr();
        end
      end else begin
        ex_pc     = rand_addr();
        ex_is_br  = ($urandom_range(0, 3) != 0);
        ex_taken  = 1'($urandom_range(0, 1));
        ex_target = rand_addr();
      end

      hm   = ex_valid && (mq.size() != 0) && (mq[0].pc == ex_pc);
      good = hm && ex_is_br && ex_taken && (mq[0].tgt == ex_target);
      m_mp = ex_valid && ((hm && !good) || (!hm && ex_is_br && ex_taken));
      corr = (hm && !(ex_is_br && ex_taken)) ? ex_pc + 32'd4 : ex_target;
      m_fv = !rst && !m_mp && !stall && !(bp_hit && (mq.size() == QD) && !good);

      #2;
      check_outputs($sformatf("rnd%0d", c), m_pc, m_fv, m_fv && bp_hit, m_mp,
                    m_bu, m_pex, m_tpc, m_cnt);

      @(posedge clk);
      if (rst) begin
        model_reset();
      end else begin
        upd = ex_valid && ex_is_br && ex_taken && !good;
        if (m_mp) begin
          mq.delete();
          m_pc = corr;
        end else begin
          if (good) void'(mq.pop_front());
          if (m_fv && bp_hit) begin
            e.pc = m_pc; e.tgt = bp_target;
            mq.push_back(e);
          end
          if (m_fv) m_pc = bp_hit ? bp_target : m_pc + 32'd4;
        end
        m_bu = upd;
        if (upd) begin
          m_pex = ex_pc;
          m_tpc = ex_target;
        end
        if (m_mp && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Fetch-stage program-counter controller that sits directly in front of the branch target buffer: it drives the lookup address, consumes the BTB hit/target prediction to choose the next PC, and tracks in-flight taken predictions. It resolves them against the EX-stage outcome, issuing flush/redirect on mispredict and generating the BTB update write (`br_update`, `target_pc`, `pc_ex`).

## Interface
- `RESET_PC`, 32'h0000_0000: fetch address after reset.
- `QDEPTH`, 4: prediction-queue entries (power of two, ≥2).
- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `stall`  in  1: IF/ID hold request from hazard logic.
- `pc_if`  out  32: current fetch PC; drives BTB `pc_in` and I-memory.
- `bp_hit`  in  1: BTB `hit` for `pc_if`.
- `bp_target`  in  32: BTB `target_predict` for `pc_if`.
- `fetch_valid`  out  1: IF/ID may capture the instruction at `pc_if` this cycle.
- `pred_taken_if`  out  1: captured instruction was predicted taken.
- `ex_valid`  in  1: a valid instruction occupies EX this cycle.
- `ex_is_br`  in  1: that instruction is a branch/jump.
- `ex_pc`  in  32: PC of the EX instruction.
- `ex_taken`  in  1: resolved direction.
- `ex_target`  in  32: resolved target.
- `flush`  out  1: kill IF/ID and ID/EX contents (combinational).
- `br_update`  out  1: BTB write strobe (registered).
- `target_pc`  out  32: BTB write target (registered).
- `pc_ex`  out  32: BTB write index/tag PC (registered).
- `mispredict_cnt`  out  16: saturating mispredict counter.

## Operation
- Prediction queue: circular FIFO of {pc, target}, head/tail pointers plus count (0..QDEPTH); `full` = count==QDEPTH.
- `pop_ok` = ex_valid & count≠0 & head.pc==ex_pc & ex_is_br & ex_taken & head.target==ex_target.
- Mispredict `mp` (combinational, only when ex_valid):
  - head match (count≠0, head.pc==ex_pc) & !ex_is_br → false hit; correct PC = ex_pc+4.
  - head match & ex_is_br & !ex_taken → correct PC = ex_pc+4.
  - head match & ex_is_br & ex_taken & target differs → correct PC = ex_target.
  - no head match & ex_is_br & ex_taken → correct PC = ex_target.
  - no head match & not taken, or non-branch: no action.
- `flush` = mp. `fetch_valid` = !rst & !mp & !stall & !(bp_hit & full & !pop_ok). `pred_taken_if` = fetch_valid & bp_hit.
- Next PC priority: rst → RESET_PC; mp → correct PC; !fetch_valid → hold; bp_hit → bp_target; else pc_if+4 (mod 2^32).
- Push {pc_if, bp_target} when fetch_valid & bp_hit; pop on pop_ok; simultaneous push+pop when full allowed, count unchanged.
- On mp: queue emptied (count=0, head=tail), any same-cycle push suppressed.
- BTB update: when ex_valid & ex_is_br & ex_taken & !pop_ok → next cycle br_update=1, pc_ex=ex_pc, target_pc=ex_target. Not-taken branches never update. ex_pc[1:0]≠0 passed unchanged (BTB ignores).
- mispredict_cnt increments on each mp cycle, saturates at 16'hFFFF.

## Timing
- Reset values: pc_if=RESET_PC, queue empty, br_update=0, target_pc=0, pc_ex=0, mispredict_cnt=0; fetch_valid=0 while rst high.
- Lookup→next PC: zero-cycle; bp_hit in cycle N selects pc_if for N+1.
- Mispredict in cycle N: flush high in N; pc_if=correct PC in N+1; br_update pulse (1 cycle) in N+1 if update rule met.
- mp overrides stall; stall holds pc_if and blocks push but not EX resolution or pop.
- rst in mid-operation discards queue and pending br_update at that edge.
- Back-to-back resolutions each produce their own one-cycle br_update.

## Test plan
- Reset with RESET_PC=32'h100, no hits, no stall → pc_if 100,104,108,…; fetch_valid=1 after rst drops; br_update=0.
- BTB hit at pc_if=0x108, bp_target=0x200 → next pc_if=0x200, queue count=1; later ex_pc=0x108 taken to 0x200 → pop, no flush, no br_update.
- Predicted-taken entry 0x108→0x200 resolves not-taken → flush in that cycle, pc_if=0x10C next, queue empty, mispredict_cnt=1, br_update=0.
- Unpredicted branch ex_pc=0x40 taken to 0x80 → flush, pc_if=0x80 next, one-cycle br_update with pc_ex=0x40, target_pc=0x80.
- Queue full (4 hits unresolved) and bp_hit again → fetch_valid=0, pc_if held; same-cycle pop_ok → push accepted, count stays 4.
- stall and mispredict in same cycle → flush wins, pc_if redirected; rst asserted while br_update pending → br_update=0, pc_if=RESET_PC next cycle.
